// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : FSM state encoding and default width for the serial adder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder.sv
// ============================================================================
// full_adder : 1-bit full adder cell used by the bit-serial datapath
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module full_adder (
   input  logic Xi,
   input  logic Yi,
   input  logic Ci,
   output logic Si,
   output logic Ci1
);

   assign Si  = Xi ^ Yi ^ Ci;
   assign Ci1 = (Xi & Yi) | (Ci & (Xi ^ Yi));

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : bit-serial {cout,sum} = a + b + cin, one bit per cycle
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic [WIDTH-1:0]   r_res_sr;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   logic               w_s;
   logic               w_co;
   logic               w_last;
   logic [WIDTH-1:0]   w_res_shifted;

   full_adder u_fa (
      .Xi  (r_a_sr[0]),
      .Yi  (r_b_sr[0]),
      .Ci  (r_carry),
      .Si  (w_s),
      .Ci1 (w_co)
   );

   assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_res_shifted = {w_s, r_res_sr[WIDTH-1:1]};

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = FIN;
         end
         FIN: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The last RUN edge writes the result registers so they are already
   // valid during the FIN cycle in which done is asserted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_res_sr <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sr   <= a;
                  r_b_sr   <= b;
                  r_carry  <= cin;
                  r_res_sr <= '0;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_carry  <= w_co;
               r_res_sr <= w_res_shifted;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_sum  <= w_res_shifted;
                  r_cout <= w_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule : serial_adder_ctrl

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// tb_serial_adder_ctrl : directed and random checks of serial_adder_ctrl
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

   logic        clk;
   logic        rst_n;
   logic        go;
   logic        sel;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        cin_in;

   logic        busy8, done8, cout8;
   logic [7:0]  sum8;
   logic        busy16, done16, cout16;
   logic [15:0] sum16;

   logic        busy_o, done_o, cout_o;
   logic [31:0] sum_o;

   int          n_tests;
   int          n_fail;
   logic [32:0] sb_q[$];
   logic [31:0] last_sum;
   logic        last_cout;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (go & ~sel),
      .a     (a_in[7:0]),
      .b     (b_in[7:0]),
      .cin   (cin_in),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (go & sel),
      .a     (a_in[15:0]),
      .b     (b_in[15:0]),
      .cin   (cin_in),
      .busy  (busy16),
      .done  (done16),
      .sum   (sum16),
      .cout  (cout16)
   );

   always_comb begin
      busy_o = sel ? busy16 : busy8;
      done_o = sel ? done16 : done8;
      cout_o = sel ? cout16 : cout8;
      sum_o  = sel ? {16'd0, sum16} : {24'd0, sum8};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; returns in the IDLE cycle after FIN so
   // that a following call exercises back-to-back acceptance.
   task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input bit disturb);
      logic [32:0] full;
      logic [31:0] mask;
      logic [32:0] exp;
      mask = (32'h1 << w) - 32'h1;
      full = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, ci};
      sb_q.push_back({full[w], full[31:0] & mask});
      a_in   = a;
      b_in   = b;
      cin_in = ci;
      go     = 1'b1;
      for (int k = 1; k <= w + 2; k++) begin
         @(posedge clk);
         #1;
         go = 1'b0;
         check($sformatf("busy k=%0d", k), 64'(busy_o), 64'(k <= w + 1));
         check($sformatf("done k=%0d", k), 64'(done_o), 64'(k == w + 1));
         if (k <= w) begin
            check($sformatf("sum held k=%0d", k), 64'(sum_o), 64'(last_sum));
            check($sformatf("cout held k=%0d", k), 64'(cout_o), 64'(last_cout));
         end else if (k == w + 1) begin
            exp = sb_q.pop_front();
            check($sformatf("sum %0h+%0h+%0b", a, b, ci), 64'(sum_o), 64'(exp[31:0]));
            check($sformatf("cout %0h+%0h+%0b", a, b, ci), 64'(cout_o), 64'(exp[32]));
            last_sum  = exp[31:0];
            last_cout = exp[32];
         end
         if (disturb && (k == 3 || k == w + 1)) begin
            go     = 1'b1;
            a_in   = ~a;
            b_in   = a;
            cin_in = ~ci;
         end
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      last_sum  = '0;
      last_cout = 1'b0;
      sel       = 1'b0;
      a_in      = 32'h0000_00AA;
      b_in      = 32'h0000_0055;
      cin_in    = 1'b1;
      rst_n     = 1'b0;
      go        = 1'b1;

      // start held high throughout reset must not launch an operation
      repeat (3) @(posedge clk);
      #1;
      check("rst busy8", 64'(busy8), 64'd0);
      check("rst done8", 64'(done8), 64'd0);
      check("rst sum8", 64'(sum8), 64'd0);
      check("rst cout8", 64'(cout8), 64'd0);
      check("rst busy16", 64'(busy16), 64'd0);
      check("rst sum16", 64'(sum16), 64'd0);
      rst_n = 1'b1;
      go    = 1'b0;
      @(posedge clk);
      #1;
      check("post-rst busy8", 64'(busy8), 64'd0);

      run_op(8, 32'h5A, 32'h3C, 1'b0, 1'b0);
      run_op(8, 32'hFF, 32'h01, 1'b0, 1'b0);
      run_op(8, 32'hFF, 32'hFF, 1'b1, 1'b0);
      run_op(8, 32'h12, 32'h34, 1'b1, 1'b1);

      // abort mid-RUN: reset sampled at edge t+5
      a_in   = 32'h77;
      b_in   = 32'h11;
      cin_in = 1'b0;
      go     = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("abort busy", 64'(busy8), 64'd0);
      check("abort done", 64'(done8), 64'd0);
      check("abort sum", 64'(sum8), 64'd0);
      check("abort cout", 64'(cout8), 64'd0);
      last_sum  = '0;
      last_cout = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("abort no done %0d", k), 64'(done8), 64'd0);
      end

      run_op(8, 32'h01, 32'h02, 1'b0, 1'b0);
      run_op(8, 32'h80, 32'h80, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++)
         run_op(8, $urandom & 32'hFF, $urandom & 32'hFF, 1'($urandom), 1'b0);

      @(posedge clk);
      #1;
      sel       = 1'b1;
      last_sum  = '0;
      last_cout = 1'b0;
      run_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
      run_op(16, 32'h1234, 32'hABCD, 1'b1, 1'b1);
      for (int i = 0; i < 1000; i++)
         run_op(16, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'($urandom), 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_serial_adder_ctrl

`default_nettype wire
